// File: rtl/fpu_pkg.sv
// Shared types and constants for the float-to-int conversion arbiter.
// Stage records carry everything a response needs, so the pipeline has no side tables.
package fpu_pkg;

    localparam int          TAG_W    = 4;
    localparam logic [7:0]  EXP_BIAS = 8'd127;
    localparam logic [7:0]  EXP_HALF = 8'd126;  // operands in [0.5, 1) round to magnitude 1
    localparam logic [7:0]  EXP_MAX  = 8'd157;  // largest exponent whose result fits in int32
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             src;
    } stage_entry_t;

    typedef struct packed {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic             src;
        logic             sat;
    } result_entry_t;

endpackage

// File: rtl/fcvt_f2i.sv
// Combinational IEEE-754 single to int32 conversion.
// Rounding is half away from zero; out-of-range, Inf and NaN saturate to INT_MIN.
module fcvt_f2i
    import fpu_pkg::*;
(
    input  logic [31:0] a,
    output logic [31:0] c,
    output logic        sat
);

    logic [7:0]  exp_f;
    logic [23:0] sig;
    logic [4:0]  sh;
    logic [32:0] rnd;
    logic [31:0] mag;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        exp_f = a[30:23];
        sig   = {1'b1, a[22:0]};
        sh    = exp_f[4:0] - EXP_BIAS[4:0];
        // Keep the integer part plus the first discarded fraction bit in rnd[0].
        rnd   = 33'(({31'd0, sig} << sh) >> 22);
        mag   = '0;
        sat   = 1'b0;
        if (exp_f > EXP_MAX) begin
            mag = INT_MIN;
            sat = 1'b1;
        end else if (exp_f == EXP_HALF) begin
            mag = 32'd1;
        end else if (exp_f > EXP_HALF) begin
            mag = rnd[32:1] + {31'd0, rnd[0]};
        end
        c = a[31] ? (~mag + 32'd1) : mag;
    end

endmodule

// File: rtl/fcvt_arb.sv
// Two-requester round-robin front end feeding a two-stage float-to-int pipeline.
// Stage 1 holds the accepted operand, stage 2 the converted result driving the response port.
module fcvt_arb
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_src,
    output logic [TAG_W-1:0] resp_tag,
    output logic [15:0]      sat_cnt,
    output logic             busy
);

    logic          run_q, run_d;
    logic          ptr_q, ptr_d;
    logic          s1_valid_q, s1_valid_d;
    stage_entry_t  s1_q, s1_d;
    logic          s2_valid_q, s2_valid_d;
    result_entry_t s2_q, s2_d;
    logic [15:0]   sat_cnt_q, sat_cnt_d;

    logic        grant0, grant1;
    logic        s1_adv, s2_adv;
    logic        acc0, acc1;
    logic [31:0] conv_c;
    logic        conv_sat;

    fcvt_f2i u_f2i (
        .a   (s1_q.data),
        .c   (conv_c),
        .sat (conv_sat)
    );

    always_comb begin
        s2_adv = !s2_valid_q || resp_ready;
        s1_adv = !s1_valid_q || s2_adv;
        grant0 = req0_valid && (!req1_valid || !ptr_q);
        grant1 = req1_valid && (!req0_valid || ptr_q);
        // run_q is cleared by reset, which keeps both readies low until the first clock after release.
        req0_ready = run_q && grant0 && s1_adv;
        req1_ready = run_q && grant1 && s1_adv;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;

        run_d      = 1'b1;
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        sat_cnt_d  = sat_cnt_q;

        if (acc0 || acc1) begin
            ptr_d = acc0;
        end

        if (s1_adv) begin
            s1_valid_d = acc0 || acc1;
            if (acc0) begin
                s1_d.data = req0_data;
                s1_d.tag  = req0_tag;
                s1_d.src  = 1'b0;
            end else if (acc1) begin
                s1_d.data = req1_data;
                s1_d.tag  = req1_tag;
                s1_d.src  = 1'b1;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.result = conv_c;
                s2_d.tag    = s1_q.tag;
                s2_d.src    = s1_q.src;
                s2_d.sat    = conv_sat;
            end
        end

        if (s2_valid_q && resp_ready && s2_q.sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q      <= 1'b0;
            ptr_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            sat_cnt_q  <= '0;
        end else begin
            run_q      <= run_d;
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign resp_valid = s2_valid_q;
    assign resp_data  = s2_q.result;
    assign resp_src   = s2_q.src;
    assign resp_tag   = s2_q.tag;
    assign sat_cnt    = sat_cnt_q;
    assign busy       = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_fcvt_arb.sv
// Randomised and directed bench for fcvt_arb against a real-arithmetic conversion model
// and a queue-based scoreboard of accepted requests.
module tb_fcvt_arb;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [3:0]  req0_tag, req1_tag;
    logic        resp_valid, resp_ready, resp_src, busy;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;
    logic [15:0] sat_cnt;

    always #5 clk = ~clk;

    fcvt_arb dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_tag   (req1_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_src   (resp_src),
        .resp_tag   (resp_tag),
        .sat_cnt    (sat_cnt),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] result;
        logic        src;
        logic [3:0]  tag;
        logic        sat;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic        src_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_stall = -1;
    logic        ptr_m = 1'b0;
    int          sat_m = 0;
    logic        dir_en = 1'b0;
    logic [31:0] dir_val = '0;
    logic        accepted = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference conversion from the real value: {sat, int32 result}.
    function automatic logic [32:0] ref_conv(input logic [31:0] f);
        int     e;
        real    v;
        longint mag;
        longint res;
        e = int'(f[30:23]);
        if (e > 157) return {1'b1, 32'h8000_0000};
        if (e < 126) return 33'd0;
        v = 1.0 + real'(f[22:0]) / 8388608.0;
        if (e == 126) v = v * 0.5;
        for (int i = 127; i < e; i++) v = v * 2.0;
        mag = longint'($floor(v + 0.5));
        res = f[31] ? -mag : mag;
        return {1'b0, res[31:0]};
    endfunction

    function automatic logic [31:0] rand_f();
        logic [7:0] e;
        if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 255));
        else                           e = 8'($urandom_range(120, 160));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Checks outputs mid-cycle, advances the model for the coming edge, then waits for the next negedge.
    task automatic tick();
        logic        room, g0, g1, src;
        exp_t        e;
        logic [32:0] r;
        #1;
        cyc++;
        accepted = 1'b0;
        if (!rstn) begin
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_data", resp_data, 0);
            check("rst_busy", busy, 0);
            check("rst_sat_cnt", sat_cnt, 0);
        end else begin
            if (!resp_ready) last_stall = cyc;
            room = (exp_q.size() < 2) || resp_ready;
            g0 = req0_valid && (!req1_valid || !ptr_m);
            g1 = req1_valid && (!req0_valid || ptr_m);
            check("req0_ready", req0_ready, g0 && room);
            check("req1_ready", req1_ready, g1 && room);
            check("busy", busy, exp_q.size() != 0);
            check("sat_cnt", sat_cnt, sat_m);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_valid_unexpected", resp_valid, 0);
                end else begin
                    e = exp_q[0];
                    check("resp_data", resp_data, e.result);
                    check("resp_src", resp_src, e.src);
                    check("resp_tag", resp_tag, e.tag);
                    if (resp_ready) begin
                        if (last_stall < e.acc_cyc) check("latency", cyc - e.acc_cyc, 2);
                        if (e.sat && sat_m < 65535) sat_m++;
                        src_log.push_back(resp_src);
                        void'(exp_q.pop_front());
                    end
                end
            end else if (exp_q.size() > 0 && last_stall < exp_q[0].acc_cyc
                         && cyc - exp_q[0].acc_cyc >= 2) begin
                check("resp_missing", resp_valid, 1);
            end
            if ((g0 || g1) && room) begin
                src = !g0;
                r = ref_conv(src ? req1_data : req0_data);
                e.result  = dir_en ? dir_val : r[31:0];
                e.sat     = r[32];
                e.src     = src;
                e.tag     = src ? req1_tag : req0_tag;
                e.acc_cyc = cyc;
                exp_q.push_back(e);
                ptr_m = !src;
                accepted = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rstn = 1'b0;
        exp_q.delete();
        ptr_m = 1'b0;
        sat_m = 0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic send(input logic p, input logic [31:0] d, input logic [3:0] t, input logic [31:0] ev);
        int n;
        n = 0;
        dir_en  = 1'b1;
        dir_val = ev;
        if (p) begin
            req1_valid = 1'b1; req1_data = d; req1_tag = t;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_tag = t;
        end
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            tick();
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        dir_en = 1'b0;
    endtask

    task automatic drive_both(input int i);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = rand_f();
        req1_data  = rand_f();
        req0_tag   = 4'(i);
        req1_tag   = 4'(i + 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_data = '0; req1_tag = '0;
        @(negedge clk);
        do_reset();

        // 1.0 from requester 0, tag 3.
        send(1'b0, 32'h3F80_0000, 4'd3, 32'd1);
        idle(4);

        send(1'b0, 32'h4020_0000, 4'd1, 32'd3);
        send(1'b1, 32'hC020_0000, 4'd2, 32'hFFFF_FFFD);
        send(1'b0, 32'h3F00_0000, 4'd5, 32'd1);
        send(1'b1, 32'h3E99_999A, 4'd6, 32'd0);
        idle(4);

        do_reset();
        send(1'b0, 32'h4F00_0000, 4'd7, 32'h8000_0000);
        send(1'b1, 32'hCF00_0000, 4'd8, 32'h8000_0000);
        idle(4);
        check("sat_cnt_two", sat_cnt, 32'd2);

        // Both requesters continuously valid: grants must alternate starting at 0.
        do_reset();
        src_log.delete();
        for (int i = 0; i < 6; i++) begin
            drive_both(i);
            tick();
        end
        idle(4);
        check("alt_count", src_log.size(), 6);
        for (int i = 0; i < 6 && i < src_log.size(); i++)
            check($sformatf("alt_src%0d", i), src_log[i], i % 2);

        // Downstream stall with both stages full, then resume.
        resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_both(i);
            tick();
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_both(i);
            tick();
        end
        idle(4);

        // Reset with two entries in flight.
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_both(i);
            tick();
        end
        check("inflight_busy", busy, 1);
        do_reset();
        resp_ready = 1'b1;
        idle(4);
        drive_both(9);
        tick();
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_data  = rand_f();
            req1_data  = rand_f();
            req0_tag   = 4'($urandom);
            req1_tag   = 4'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        resp_ready = 1'b1;
        idle(6);
        check("final_drained", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
